// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared opcodes, state encoding and op decode helpers for div_unit
//
// Purpose: single source for the divOp encodings and FSM states used by the
// divider control and datapath.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_t;

  // Bit 0 of the opcode selects unsigned; bit 1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Purpose: shift the partial remainder left, bring in one dividend bit and
// trial-subtract the divisor.
// Ports:
//   rem      in  WIDTH  current partial remainder (always < dsr)
//   dvd_bit  in  1      next dividend bit, MSB first
//   dsr      in  WIDTH  divisor magnitude
//   rem_next out WIDTH  next partial remainder
//   q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem, dvd_bit};
  // No borrow on the trial subtract means the divisor fits.
  assign fits    = (shifted >= {1'b0, dsr});
  assign q_bit   = fits;
  // When it fits the difference is below 2^WIDTH, so a WIDTH-bit subtract of
  // the low bits is exact.
  assign rem_next = fits ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV64M DIV/DIVU/REM/REMU unit
//
// Purpose: iterative restoring divider with fixed WIDTH+2 cycle latency.
// Ports:
//   clk     in  1      rising-edge clock
//   reset   in  1      asynchronous active-high reset
//   start   in  1      request, sampled only when busy=0
//   divOp   in  2      00=DIV 01=DIVU 10=REM 11=REMU
//   X       in  WIDTH  dividend
//   Y       in  WIDTH  divisor
//   busy    out 1      operation in progress
//   done    out 1      one-cycle pulse, divOut valid
//   divOut  out WIDTH  quotient or remainder, held until next result
//   divZero out 1      last result had Y==0
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       divOp,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] divOut,
  output logic             divZero
);

  div_state_t state, state_n;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q;     // dividend, then shifts into quotient
  logic [WIDTH-1:0] y_q;     // divisor, magnitude after PREP
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt;
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             sgn;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_step;

  assign sgn       = op_is_signed(op_q);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_bit  (x_q[WIDTH-1]),
    .dsr      (y_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: state_n = start ? ST_PREP : ST_IDLE;
      ST_PREP:          state_n = ST_ITER;
      ST_ITER:          state_n = last_step ? ST_FIX : ST_ITER;
      ST_FIX:           state_n = ST_DONE;
      default:          state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
  assign done = (state == ST_DONE);

  // Overflow (most-negative / -1) needs no special case: the magnitude wraps
  // back to the most-negative value and the remainder is naturally zero.
  // Divide-by-zero leaves |X| as remainder, so only the signed quotient
  // needs forcing to all ones.
  always_comb begin
    q_fix = qneg_q ? -x_q : x_q;
    r_fix = rneg_q ? -rem_q : rem_q;
    if (zero_q) q_fix = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      cnt     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      divOut  <= '0;
      divZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q <= divOp;
            x_q  <= X;
            y_q  <= Y;
          end
        end
        ST_PREP: begin
          zero_q <= (y_q == '0);
          qneg_q <= sgn & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
          rneg_q <= sgn & x_q[WIDTH-1];
          x_q    <= (sgn && x_q[WIDTH-1]) ? -x_q : x_q;
          y_q    <= (sgn && y_q[WIDTH-1]) ? -y_q : y_q;
          rem_q  <= '0;
          cnt    <= '0;
        end
        ST_ITER: begin
          rem_q <= step_rem;
          x_q   <= {x_q[WIDTH-2:0], step_q};
          cnt   <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          divOut  <= op_is_rem(op_q) ? r_fix : q_fix;
          divZero <= zero_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
module tb_div_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   divOp;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic [W-1:0] divOut;
  logic         divZero;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_unit #(.WIDTH(W), .CNT_W(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .divOp   (divOp),
    .X       (X),
    .Y       (Y),
    .busy    (busy),
    .done    (done),
    .divOut  (divOut),
    .divZero (divZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (divOut=%h)", divOut);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, divOut, mon_e.res);
        check({mon_e.name, "_divzero"}, W'(divZero), W'(mon_e.z));
        check({mon_e.name, "_latency"}, W'(cyc), W'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    divOp = op;
    X     = x;
    Y     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Disturb the inputs to show the operands were latched.
    X     = {$urandom, $urandom};
    Y     = {$urandom, $urandom};
    divOp = 2'($urandom);
  endtask

  task automatic push(input string name, input logic [W-1:0] res, input logic z);
    sb.push_back('{res: res, z: z, cyc: cyc + W + 2, name: name});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] res, input logic z);
    issue(op, x, y);
    push(name, res, z);
    wait_done(name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit busy_ok;
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    divOp = 2'b00;
    X     = '0;
    Y     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_divout", divOut, '0);
    check("reset_divzero", W'(divZero), '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // DIVU 100/7 with busy held for the whole operation.
    issue(2'b01, 64'd100, 64'd7);
    push("divu_100_7", 64'd14, 1'b0);
    busy_ok = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    end
    check("busy_window", W'(busy_ok), W'(1));
    wait_done("divu_100_7");
    repeat (2) @(negedge clk);

    run_op("remu_100_7",  2'b11, 64'd100, 64'd7, 64'd2, 1'b0);
    run_op("div_m100_7",  2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
    run_op("rem_m100_7",  2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("rem_100_m7",  2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0);
    run_op("divu_by0",    2'b01, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("rem_m5_by0",  2'b10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    run_op("div_ovf",     2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b0);
    run_op("rem_ovf",     2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

    // Start while busy is ignored, then back-to-back start in the DONE cycle.
    issue(2'b01, 64'd750, 64'd250);
    push("divu_750_250", 64'd3, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    divOp = 2'b01;
    X     = 64'd12345;
    Y     = 64'd2345;
    @(negedge clk);
    start = 1'b0;
    wait_done("divu_750_250");
    start = 1'b1;
    divOp = 2'b01;
    X     = 64'd25;
    Y     = 64'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    push("b2b_divu_25_5", 64'd5, 1'b0);
    @(negedge clk);
    check("b2b_done_drops", W'(done), '0);
    check("b2b_busy", W'(busy), W'(1));
    check("b2b_divout_held", divOut, 64'd3);
    wait_done("b2b_divu_25_5");
    repeat (2) @(negedge clk);

    // Reset 10 cycles into an operation aborts it without a done pulse.
    issue(2'b01, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_divout", divOut, '0);
    check("abort_divzero", W'(divZero), '0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (W + 16) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", W'(saw_done), '0);
    run_op("divu_128_64", 2'b01, 64'd128, 64'd64, 64'd2, 1'b0);

    check("scoreboard_empty", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
